// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store stage behind the ALU.
// Takes the ALU result as the effective address and operand b as store data.
// It issues one byte, halfword or word access over a request/ready memory
// handshake, and returns the lane-extracted, sign- or zero-extended load data.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             request strobe, sampled only in IDLE
//   ld, st            load / store qualifiers
//   size              00 byte, 01 halfword, 10 word, 11 illegal
//   sext              loads: 1 sign-extend, 0 zero-extend
//   addr, wdata       effective address, store data
//   busy              high in REQ and DONE (pipeline stall)
//   done, err         one-cycle completion pulse, error flag valid with done
//   rdata             extended load result, held between accesses
//   mem_req/we/addr/be/wdata   memory request side (registered)
//   mem_ready, mem_rdata       memory response side
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld,
    input  logic        st,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_rdata;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [DW-1:0]   r_mem_addr;
    logic [BW-1:0]   r_mem_be;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_is_load;
    logic [1:0]      r_size;
    logic            r_sext;
    logic [1:0]      r_a;

    logic            w_reject;
    logic [BW-1:0]   w_be;
    logic [DW-1:0]   w_wrep;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [DW-1:0]   w_load;

    // Request legality and byte-lane setup, decoded from the live request inputs
    always_comb begin
        w_reject = 1'b0;
        w_be     = 4'b1111;
        w_wrep   = wdata;
        if (ld && st)
            w_reject = 1'b1;
        case (size)
            SZ_BYTE: begin
                w_be   = 4'b0001 << addr[1:0];
                w_wrep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be   = 4'b0011 << addr[1:0];
                w_wrep = {2{wdata[15:0]}};
                if (addr[0])
                    w_reject = 1'b1;
            end
            SZ_WORD: begin
                if (addr[1:0] != 2'b00)
                    w_reject = 1'b1;
            end
            default: w_reject = 1'b1;
        endcase
    end

    // Lane extraction and extension of the returned read word
    always_comb begin
        w_byte = 8'(mem_rdata >> {r_a, 3'b000});
        w_half = 16'(mem_rdata >> {r_a[1], 4'b0000});
        case (r_size)
            SZ_BYTE: w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_is_load   <= 1'b0;
            r_size      <= SZ_BYTE;
            r_sext      <= 1'b0;
            r_a         <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A strobe with neither qualifier is silently dropped
                    if (start && (ld || st)) begin
                        r_busy <= 1'b1;
                        if (w_reject) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= st;
                            r_is_load   <= ld;
                            r_size      <= size;
                            r_sext      <= sext;
                            r_a         <= addr[1:0];
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wrep;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_is_load)
                            r_rdata <= w_load;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized bench for load_store_unit with an
// arithmetic reference model for legality, byte enables, store replication and
// load extension.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_rdata;
    logic [31:0] exp_mem_addr;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ld        (ld),
        .st        (st),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: access of 2**sz bytes must be naturally aligned
    function automatic bit f_reject(bit l, bit s, logic [1:0] sz, logic [31:0] a);
        int nbytes;
        if (l && s) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        nbytes = 1 << sz;
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [3:0] f_be(logic [1:0] sz, logic [1:0] a);
        int lanes;
        if (sz == 2'd2) return 4'd15;
        lanes = (1 << (1 << sz)) - 1;
        return 4'(lanes << a);
    endfunction

    function automatic logic [31:0] f_rep(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return 32'(d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return 32'(d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] f_load(logic [1:0] sz, bit sx, logic [1:0] a, logic [31:0] word);
        longint v;
        int bits;
        bits = 8 << sz;
        if (bits == 32) return word;
        v = (longint'(word) >> (8 * int'(a))) % (longint'(1) << bits);
        if (sx && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    // One request from IDLE to IDLE; called and returns on a falling edge
    task automatic run_txn(input bit i_ld, input bit i_st, input logic [1:0] i_size,
                           input bit i_sext, input logic [31:0] i_addr,
                           input logic [31:0] i_wdata, input logic [31:0] i_word,
                           input int n_wait, input bit poke);
        bit ign;
        bit rej;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        ign  = !i_ld && !i_st;
        rej  = !ign && f_reject(i_ld, i_st, i_size, i_addr);
        e_be = f_be(i_size, i_addr[1:0]);
        e_wd = f_rep(i_size, i_wdata);
        start = 1'b1; ld = i_ld; st = i_st; size = i_size; sext = i_sext;
        addr = i_addr; wdata = i_wdata;
        @(negedge clk);
        start = 1'b0; addr = $urandom; wdata = $urandom; sext = 1'($urandom);
        if (ign) begin
            check("ign_busy", busy, 0);
            check("ign_done", done, 0);
            check("ign_req", mem_req, 0);
            check("ign_addr", mem_addr, exp_mem_addr);
        end else if (rej) begin
            check("rej_done", done, 1);
            check("rej_err", err, 1);
            check("rej_busy", busy, 1);
            check("rej_req", mem_req, 0);
            check("rej_rdata", rdata, exp_rdata);
            check("rej_addr", mem_addr, exp_mem_addr);
        end else begin
            exp_mem_addr = i_addr & 32'hFFFF_FFFC;
            for (int w = 0; w <= n_wait; w++) begin
                check("req_req", mem_req, 1);
                check("req_we", mem_we, i_st);
                check("req_addr", mem_addr, exp_mem_addr);
                check("req_be", mem_be, e_be);
                if (i_st) check("req_wdata", mem_wdata, e_wd);
                check("req_done", done, 0);
                check("req_busy", busy, 1);
                if (w < n_wait) begin
                    mem_rdata = $urandom;
                    if (poke) begin
                        start = 1'($urandom); ld = 1'b1; st = 1'($urandom);
                        size = 2'($urandom); addr = $urandom;
                    end
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            mem_ready = 1'b1;
            mem_rdata = i_word;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (i_ld) exp_rdata = f_load(i_size, i_sext, i_addr[1:0], i_word);
            check("cmp_done", done, 1);
            check("cmp_err", err, 0);
            check("cmp_rdata", rdata, exp_rdata);
            check("cmp_req", mem_req, 0);
            check("cmp_we", mem_we, 0);
            check("cmp_busy", busy, 1);
        end
        // Ready outside REQ must be ignored
        mem_ready = 1'($urandom);
        @(negedge clk);
        mem_ready = 1'b0;
        check("end_done", done, 0);
        check("end_busy", busy, 0);
        check("end_req", mem_req, 0);
        check("end_rdata", rdata, exp_rdata);
        check("end_addr", mem_addr, exp_mem_addr);
    endtask

    initial begin
        bit          r_ld;
        bit          r_st;
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        int          op;

        reset = 1'b1; start = 1'b0; ld = 1'b0; st = 1'b0; size = 2'b00;
        sext = 1'b0; addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        exp_rdata = '0; exp_mem_addr = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_be", mem_be, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
        run_txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 1, 0);
        check("lb_sext", rdata, 32'hFFFFFF80);
        run_txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 1, 0);
        check("lbu", rdata, 32'h00000080);
        run_txn(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h0, 0, 0);
        check("sh_rdata_kept", rdata, 32'h00000080);
        run_txn(1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0, 0);
        run_txn(1, 1, 2'd2, 0, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn(1, 0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn(0, 0, 2'd2, 0, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn(1, 0, 2'd1, 1, 32'h302, 32'h0, 32'h8001_7FFF, 3, 1);

        // Reset while waiting for memory
        start = 1'b1; ld = 1'b1; st = 1'b0; size = 2'd2; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        check("mid_req", mem_req, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_be", mem_be, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        exp_rdata = '0;
        exp_mem_addr = '0;
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("post_rst_done", done, 0);
        check("post_rst_req", mem_req, 0);
        run_txn(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'hCAFEF00D, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            op = int'($urandom_range(0, 9));
            r_ld = (op == 1) || (op >= 2 && op <= 5);
            r_st = (op == 1) || (op >= 6);
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0 && r_size != 2'd3)
                r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
            run_txn(r_ld, r_st, r_size, 1'($urandom), r_addr, $urandom, $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
